// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions
// and active-high hex glyphs in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  localparam logic [6:0] HEX_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] HEX_1 = M_B | M_C;
  localparam logic [6:0] HEX_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] HEX_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] HEX_4 = M_B | M_C | M_F | M_G;
  localparam logic [6:0] HEX_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] HEX_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] HEX_7 = M_A | M_B | M_C;
  localparam logic [6:0] HEX_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] HEX_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] HEX_A = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [6:0] HEX_B = M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] HEX_C = M_A | M_D | M_E | M_F;
  localparam logic [6:0] HEX_D = M_B | M_C | M_D | M_E | M_G;
  localparam logic [6:0] HEX_E = M_A | M_D | M_E | M_F | M_G;
  localparam logic [6:0] HEX_F = M_A | M_E | M_F | M_G;

  // All segments dark, in the active-high ("on" = 1) sense.
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph, active-high, {g..a} order.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = HEX_0;
    case (nibble)
      4'h0: pattern = HEX_0;
      4'h1: pattern = HEX_1;
      4'h2: pattern = HEX_2;
      4'h3: pattern = HEX_3;
      4'h4: pattern = HEX_4;
      4'h5: pattern = HEX_5;
      4'h6: pattern = HEX_6;
      4'h7: pattern = HEX_7;
      4'h8: pattern = HEX_8;
      4'h9: pattern = HEX_9;
      4'hA: pattern = HEX_A;
      4'hB: pattern = HEX_B;
      4'hC: pattern = HEX_C;
      4'hD: pattern = HEX_D;
      4'hE: pattern = HEX_E;
      4'hF: pattern = HEX_F;
      default: pattern = HEX_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver stepped by a synchronised scan clock, with
// frame-aligned double buffering and a blanking guard after each digit switch.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int GUARD          = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_50MHz,
  input  logic                    rst_n,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   dot_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    data_load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [GW-1:0]         GUARD_LOAD = GW'(GUARD);
  localparam logic [7:0]            SEG_POL    = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL    = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic s1, s2, s3, tick, boundary;
  logic [IW-1:0] idx;
  logic [GW-1:0] guard_cnt;
  logic          pending;
  logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
  logic [NUM_DIGITS-1:0]   shadow_dot, active_dot, shadow_blank, active_blank;

  // scan_clk is plain data from another domain: two flops for metastability,
  // a third to find the rising edge.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick     = s2 & ~s3;
  assign boundary = tick && (idx == LAST_IDX);

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      frame_done <= 1'b0;
      guard_cnt  <= '0;
    end else begin
      frame_done <= boundary;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      if (tick) guard_cnt <= GUARD_LOAD;
      else if (guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
    end
  end

  // data_load is a one-cycle strobe with no back-pressure: every asserted
  // cycle overwrites the shadow; the active copy only changes at a frame wrap,
  // so a load coinciding with the wrap is held over to the next one.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data  <= '0;
      shadow_dot   <= '0;
      shadow_blank <= '1;
      active_data  <= '0;
      active_dot   <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
    end else begin
      if (boundary && pending) begin
        active_data  <= shadow_data;
        active_dot   <= shadow_dot;
        active_blank <= shadow_blank;
      end
      if (data_load) begin
        shadow_data  <= disp_data;
        shadow_dot   <= dot_in;
        shadow_blank <= blank_in;
      end
      if (data_load)     pending <= 1'b1;
      else if (boundary) pending <= 1'b0;
    end
  end

  logic [3:0]            cur_nibble;
  logic                  cur_dot, cur_blank, display_en;
  logic [6:0]            cur_pat;
  logic [NUM_DIGITS-1:0] dig_on, dig_d;
  logic [7:0]            seg_on, seg_d;

  always_comb begin
    cur_nibble = '0;
    cur_dot    = 1'b0;
    cur_blank  = 1'b1;
    dig_on     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble = active_data[4*i +: 4];
        cur_dot    = active_dot[i];
        cur_blank  = active_blank[i];
        dig_on[i]  = 1'b1;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble  (cur_nibble),
    .pattern (cur_pat)
  );

  always_comb begin
    display_en     = (guard_cnt == '0) && !cur_blank;
    seg_on         = {1'b0, cur_pat};
    seg_on[SEG_DP] = cur_dot;
    seg_d          = (display_en ? seg_on : SEG_OFF) ^ SEG_POL;
    dig_d          = (display_en ? dig_on : '0) ^ DIG_POL;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_OFF ^ SEG_POL;
      dig_sel <= DIG_POL;
    end else begin
      seg     <= seg_d;
      dig_sel <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table vectors, hand sequences for the frame and
// reset corners, and randomized loads against a digit-level reference model.
module tb_seg7_scan_driver;

  localparam int N     = 8;
  localparam int GUARD = 50;

  logic        clk_50MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        scan_clk  = 1'b0;
  logic        data_load = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0]  dot_in    = '0;
  logic [7:0]  blank_in  = '0;
  logic [7:0]  seg;
  logic [7:0]  dig_sel;
  logic        frame_done;

  int checks       = 0;
  int failures     = 0;
  int frame_pulses = 0;

  // Reference model: what each digit should show, tracked per scan step.
  logic [31:0] sh_data, act_data;
  logic [7:0]  sh_dot, act_dot, sh_blank, act_blank;
  bit          pending;
  int          exp_idx;
  logic [7:0]  exp_q[$];

  string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dot;
    logic [7:0]  blank;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  dig0;
    logic [7:0]  dig1;
  } vec_t;

  vec_t vecs [4];

  seg7_scan_driver #(
    .NUM_DIGITS     (N),
    .GUARD          (GUARD),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .disp_data  (disp_data),
    .dot_in     (dot_in),
    .blank_in   (blank_in),
    .data_load  (data_load),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) if (frame_done) frame_pulses++;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pattern_of(input logic [3:0] n);
    string      s;
    logic [6:0] p;
    p = '0;
    s = seg_names[n];
    for (int c = 0; c < s.len(); c++) p[int'(s[c]) - 97] = 1'b1;
    return p;
  endfunction

  task automatic exp_display(input int i, output logic [7:0] s, output logic [7:0] d);
    if (act_blank[i]) begin
      s = 8'hFF;
      d = 8'hFF;
    end else begin
      s = ~{act_dot[i], pattern_of(act_data[4*i +: 4])};
      d = ~(8'h01 << i);
    end
  endtask

  task automatic model_reset();
    exp_idx   = 0;
    sh_data   = '0;
    act_data  = '0;
    sh_dot    = '0;
    act_dot   = '0;
    sh_blank  = '1;
    act_blank = '1;
    pending   = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dt, input logic [7:0] bl);
    @(posedge clk_50MHz); #1;
    disp_data = d;
    dot_in    = dt;
    blank_in  = bl;
    data_load = 1'b1;
    @(posedge clk_50MHz); #1;
    data_load = 1'b0;
    sh_data   = d;
    sh_dot    = dt;
    sh_blank  = bl;
    pending   = 1'b1;
  endtask

  // One scan_clk rising edge, observed cycle by cycle through the guard.
  task automatic step(input bit load_now, input logic [31:0] ld_d,
                      input logic [7:0] ld_dot, input logic [7:0] ld_blank);
    logic [7:0] os, od, ns, nd;
    bit         bnd;
    exp_display(exp_idx, os, od);
    ns  = 8'hFF;
    nd  = 8'hFF;
    bnd = (exp_idx == N - 1);
    @(posedge clk_50MHz); #1;
    scan_clk = 1'b1;
    for (int k = 1; k <= GUARD + 5; k++) begin
      @(posedge clk_50MHz); #1;
      if (k == 2 && load_now) begin
        disp_data = ld_d;
        dot_in    = ld_dot;
        blank_in  = ld_blank;
        data_load = 1'b1;
      end
      if (k == 3) begin
        data_load = 1'b0;
        if (bnd && pending) begin
          act_data  = sh_data;
          act_dot   = sh_dot;
          act_blank = sh_blank;
          pending   = 1'b0;
        end
        if (load_now) begin
          sh_data  = ld_d;
          sh_dot   = ld_dot;
          sh_blank = ld_blank;
          pending  = 1'b1;
        end
        exp_idx = (exp_idx + 1) % N;
        exp_display(exp_idx, ns, nd);
      end
      if (k == 12) scan_clk = 1'b0;
      @(negedge clk_50MHz);
      if (k == 2) check8("fd_early", {7'b0, frame_done}, 8'h00);
      if (k == 3) begin
        check8("fd_pulse", {7'b0, frame_done}, {7'b0, bnd});
        check8("seg_hold", seg, os);
        check8("dig_hold", dig_sel, od);
      end
      if (k == 4) check8("fd_clear", {7'b0, frame_done}, 8'h00);
      if (k >= 4 && k <= GUARD + 3) begin
        check8("guard_seg", seg, 8'hFF);
        check8("guard_dig", dig_sel, 8'hFF);
      end
      if (k >= GUARD + 4) begin
        check8("disp_seg", seg, ns);
        check8("disp_dig", dig_sel, nd);
      end
    end
  endtask

  task automatic advance_to(input int target);
    while (exp_idx != target) step(1'b0, '0, '0, '0);
  endtask

  initial begin
    vecs[0] = '{32'h76543210, 8'h01, 8'h00, 8'h40, 8'hF9, 8'hFE, 8'hFD};
    vecs[1] = '{32'h000000FA, 8'h02, 8'h00, 8'h88, 8'h0E, 8'hFE, 8'hFD};
    vecs[2] = '{32'h000000B8, 8'h00, 8'h02, 8'h80, 8'hFF, 8'hFE, 8'hFF};
    vecs[3] = '{32'h00000017, 8'h03, 8'h00, 8'h78, 8'h79, 8'hFE, 8'hFD};

    model_reset();
    repeat (3) @(negedge clk_50MHz);
    check8("rst_seg", seg, 8'hFF);
    check8("rst_dig", dig_sel, 8'hFF);
    check8("rst_fd", {7'b0, frame_done}, 8'h00);
    rst_n = 1'b1;

    // Three dark frames with no load.
    frame_pulses = 0;
    for (int i = 0; i < 3 * N; i++) step(1'b0, '0, '0, '0);
    check8("dark_frames", 8'(frame_pulses), 8'd3);

    // Table vectors: load, wrap a frame, read digits 0 and 1.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].data, vecs[v].dot, vecs[v].blank);
      exp_q.push_back(vecs[v].seg0);
      exp_q.push_back(vecs[v].seg1);
      advance_to(N - 1);
      step(1'b0, '0, '0, '0);
      check8("tbl_seg0", seg, exp_q.pop_front());
      check8("tbl_dig0", dig_sel, vecs[v].dig0);
      step(1'b0, '0, '0, '0);
      check8("tbl_seg1", seg, exp_q.pop_front());
      check8("tbl_dig1", dig_sel, vecs[v].dig1);
    end

    // Mid-frame load: digits 4..7 keep the old zeros until the wrap.
    advance_to(3);
    do_load(32'h11111111, 8'h00, 8'h00);
    for (int i = 4; i < N; i++) begin
      step(1'b0, '0, '0, '0);
      check8("midload_old", seg, 8'hC0);
    end
    step(1'b0, '0, '0, '0);
    check8("midload_new", seg, 8'hF9);

    // Load coincident with the wrap: older pending shadow shows first.
    advance_to(4);
    do_load(32'h33333333, 8'h00, 8'h00);
    advance_to(N - 1);
    step(1'b1, 32'h22222222, 8'h00, 8'h00);
    check8("coinc_old", seg, 8'hB0);
    advance_to(N - 1);
    step(1'b0, '0, '0, '0);
    check8("coinc_new", seg, 8'hA4);

    // Randomized loads against the model.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) do_load($urandom, 8'($urandom), 8'($urandom & $urandom));
      if (r == 1) begin
        do_load($urandom, 8'($urandom), 8'($urandom));
        do_load($urandom, 8'($urandom), 8'($urandom & $urandom));
      end
      step($urandom_range(0, 7) == 0, $urandom, 8'($urandom), 8'($urandom & $urandom));
    end

    // Asynchronous reset while digit 5 is lit.
    do_load($urandom, 8'($urandom), 8'h00);
    advance_to(N - 1);
    step(1'b0, '0, '0, '0);
    advance_to(5);
    check8("pre_rst_dig", dig_sel, 8'hDF);
    @(negedge clk_50MHz); #2;
    rst_n = 1'b0;
    #1;
    check8("arst_seg", seg, 8'hFF);
    check8("arst_dig", dig_sel, 8'hFF);
    check8("arst_fd", {7'b0, frame_done}, 8'h00);
    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) step(1'b0, '0, '0, '0);
    do_load(32'h76543210, 8'h01, 8'h00);
    advance_to(N - 1);
    step(1'b0, '0, '0, '0);
    check8("post_rst_seg0", seg, 8'h40);
    advance_to(3);
    check8("post_rst_dig3", dig_sel, 8'hF7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed seven-segment display driver; the consumer end of the 10 kHz scan clock produced by the clock divider.
- Receives the scan clock as a plain signal and synchronises it into the clk_50MHz domain. Each rising edge steps to the next digit.
- Display data goes through a shadow/active double buffer, so updates take effect only at frame boundaries (no tearing).
- Inserts a blanking guard interval at each digit switch to suppress ghosting.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits (2..8).
- GUARD, 50: clk_50MHz cycles with all digits off after each digit switch (50 = 1 us); 0 disables the guard.
- SEG_ACTIVE_LOW, 1: 1 means segment lines are driven low for "on".
- DIG_ACTIVE_LOW, 1: 1 means digit selects are driven low for "on".

Ports:
- clk_50MHz  in  1  system clock
- rst_n  in  1  reset (asynchronous, active-low)
- scan_clk  in  1  10 kHz scan clock from the divider; treated as asynchronous data, not as a clock
- disp_data  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
- dot_in  in  NUM_DIGITS  decimal point per digit
- blank_in  in  NUM_DIGITS  1 = digit dark
- data_load  in  1  capture disp_data, dot_in and blank_in into shadow
- seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - idx=0, guard_cnt=0, pending=0.
  - Shadow/active data and dots = 0; shadow/active blank = all 1 (dark).
  - seg = all "off", dig_sel = all "off", frame_done=0.
- Synchroniser: scan_clk → s1 → s2 → s3; tick = s2 & ~s3.
  - tick asserts on the 3rd clk_50MHz edge after the scan_clk rise; exactly one cycle per rising edge.
  - Falling edges are ignored.
- Digit index idx, 0..NUM_DIGITS-1:
  - Increments on tick.
  - Wraps NUM_DIGITS-1 → 0.
- Frame boundary (tick while idx==NUM_DIGITS-1):
  - frame_done=1 for the following cycle.
  - If pending: active ← shadow, pending ← 0.
- Load:
  - data_load=1: shadow ← inputs, pending ← 1.
  - Repeated loads within a frame: last one wins.
  - Load in the same cycle as a frame boundary: active takes the old shadow, shadow takes the new inputs, pending stays 1 (new data is applied at the next boundary).
- Guard:
  - On tick, guard_cnt ← GUARD.
  - While guard_cnt≠0: decrement each cycle; dig_sel all off, seg all off.
  - GUARD=0: no blanking.
- Display phase (guard_cnt==0):
  - dig_sel asserts bit idx only.
  - seg = decode(active nibble idx) with dp = active dot[idx].
  - If active blank[idx]=1: seg all off and dig_sel all off.
- Output registration: seg and dig_sel are registered, one cycle after the internal state. Never more than one digit is on.
- Hex decode (a..g bits, "on" sense), standard patterns:
  - 0 = a b c d e f
  - 1 = b c
  - 7 = a b c
  - 8 = all seven
  - A = a b c e f g
  - b = c d e f g
  - F = a e f g
- Polarity: applied as the final XOR stage.
- scan_clk stuck at either level: current digit is held indefinitely; no watchdog.

Decomposition:
- Package seg7_pkg:
  - segment bit-index constants (SEG_A..SEG_DP)
  - 7-bit pattern constants for hex 0-F
  - SEG_OFF constant
- Sub-module seg7_hex_decode: combinational nibble → 7-bit pattern, active-high.
- Synchroniser, counter, buffering, guard and output stages stay in seg7_scan_driver.

Test Plan:
- Reset release with no load → seg=8'hFF and dig_sel=8'hFF (dark) for 3 full frames; frame_done pulses every 8 ticks.
- Load disp_data=32'h76543210, blank=0, dot=8'h01, then one frame boundary → digit 0 shows seg=8'h40 (0 plus dp, active-low); digit 1 shows 8'hF9; dig_sel for digit 3 = 8'hF7.
- Single scan_clk rising edge → tick after exactly 3 clk; dig_sel all off for 50 cycles, then the next digit turns on on cycle 51 after tick (+1 register stage).
- Load 32'h11111111 mid-frame at idx=3 → digits 4..7 still show old data; new data appears only after the next frame_done.
- data_load coincident with the frame-boundary tick → old shadow is displayed for that frame, new data the frame after.
- rst_n asserted while digit 5 is lit → seg/dig_sel go off asynchronously in the same cycle; after release idx=0 and the display is dark until a load plus a boundary.
